// File: rtl/main_mem_ctrl_pkg.sv
// rtl/main_mem_ctrl_pkg.sv - shared state encoding, default widths and CPU instruction field constants
package main_mem_ctrl_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 8;
  localparam int BUS_ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  // Instruction word layout: 2-bit opcode on top, 8-bit word address at the bottom.
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 14;
  localparam int OPND_W  = 8;
  localparam logic [1:0] OPC_LOAD  = 2'b00;
  localparam logic [1:0] OPC_STORE = 2'b01;
  localparam logic [1:0] OPC_ALU   = 2'b10;
  localparam logic [1:0] OPC_JUMP  = 2'b11;

  function automatic logic [1:0] opcode_of(input logic [DATA_W_DEF-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/main_mem_ctrl_if.sv
// rtl/main_mem_ctrl_if.sv - CPU request/ack bus plus boot-load stream
interface main_mem_ctrl_if
  import main_mem_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int BUS_ADDR_W = BUS_ADDR_W_DEF
);
  logic                  req;
  logic                  we;
  logic [BUS_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;
  logic                  err;
  logic                  busy;
  logic                  ld_valid;
  logic [DATA_W-1:0]     ld_data;
  logic                  ld_ready;
  logic                  ld_full;

  modport master (
    output req, we, addr, wdata, ld_valid, ld_data,
    input  rdata, ack, err, busy, ld_ready, ld_full
  );

  modport slave (
    input  req, we, addr, wdata, ld_valid, ld_data,
    output rdata, ack, err, busy, ld_ready, ld_full
  );
endinterface

// File: rtl/main_mem_ctrl_mem_array.sv
// rtl/main_mem_ctrl_mem_array.sv - single-port RAM, synchronous write and enabled synchronous read
module main_mem_ctrl_mem_array
  import main_mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/main_mem_ctrl.sv
// rtl/main_mem_ctrl.sv - wait-stated main memory controller with range check and boot-load port
module main_mem_ctrl
  import main_mem_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int BUS_ADDR_W = BUS_ADDR_W_DEF,
  parameter int WAIT_CYC   = 1
) (
  input  logic            clk,
  input  logic            rst,
  main_mem_ctrl_if.slave  bus
);
  localparam int HI_W  = BUS_ADDR_W - ADDR_W;
  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  state_e                state_q;
  logic                  we_q;
  logic [BUS_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  ack_q;
  logic                  err_q;
  logic                  zero_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]     ld_ptr_q;
  logic                  ld_full_q;

  logic                  in_range;
  logic                  load_fire;
  logic                  accept;
  logic                  ram_we;
  logic                  ram_re;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  generate
    if (HI_W > 0) begin : g_hi
      assign in_range = (addr_q[BUS_ADDR_W-1:ADDR_W] == '0);
    end else begin : g_nohi
      assign in_range = 1'b1;
    end
  endgenerate

  assign load_fire = (state_q == ST_IDLE) && bus.ld_valid && !ld_full_q;
  assign accept    = (state_q == ST_IDLE) && bus.req && !ack_q && !bus.ld_valid;

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = ld_ptr_q;
    ram_wdata = bus.ld_data;
    if (load_fire) begin
      ram_we = 1'b1;
    end else if (state_q == ST_ACC && in_range) begin
      ram_addr  = addr_q[ADDR_W-1:0];
      ram_wdata = wdata_q;
      ram_we    = we_q;
      ram_re    = !we_q;
    end
  end

  main_mem_ctrl_mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      zero_q    <= 1'b1;
      cnt_q     <= '0;
      ld_ptr_q  <= '0;
      ld_full_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_fire) begin
            if (&ld_ptr_q) ld_full_q <= 1'b1;
            else           ld_ptr_q  <= ld_ptr_q + 1'b1;
          end else if (accept) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            cnt_q   <= '0;
            state_q <= (WAIT_CYC == 0) ? ST_ACC : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(WAIT_CYC - 1)) state_q <= ST_ACC;
          else                              cnt_q   <= cnt_q + 1'b1;
        end
        ST_ACC: begin
          ack_q   <= 1'b1;
          state_q <= ST_IDLE;
          // rdata is the RAM read register unless masked; only reads and misses touch it
          if (!in_range) begin
            err_q  <= 1'b1;
            zero_q <= 1'b1;
          end else if (!we_q) begin
            zero_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rdata    = zero_q ? '0 : ram_rdata;
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.ld_ready = (state_q == ST_IDLE) && !ld_full_q;
  assign bus.ld_full  = ld_full_q;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb/tb_main_mem_ctrl.sv - randomized self-checking bench for main_mem_ctrl (WAIT_CYC=0 and 1 instances)
module tb_main_mem_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int BW = 16;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_s   [2];
  logic          req_s   [2];
  logic          we_s    [2];
  logic [BW-1:0] addr_s  [2];
  logic [DW-1:0] wdata_s [2];
  logic          ldv_s   [2];
  logic [DW-1:0] ldd_s   [2];
  logic [DW-1:0] rdata_s [2];
  logic          ack_s   [2];
  logic          err_s   [2];
  logic          busy_s  [2];
  logic          ldr_s   [2];
  logic          ldf_s   [2];

  main_mem_ctrl_if #(.DATA_W(DW), .BUS_ADDR_W(BW)) bus0 ();
  main_mem_ctrl_if #(.DATA_W(DW), .BUS_ADDR_W(BW)) bus1 ();

  main_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BUS_ADDR_W(BW), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst_s[0]), .bus(bus0));
  main_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .BUS_ADDR_W(BW), .WAIT_CYC(1)) dut1 (
    .clk(clk), .rst(rst_s[1]), .bus(bus1));

  assign bus0.req = req_s[0];   assign bus1.req = req_s[1];
  assign bus0.we = we_s[0];     assign bus1.we = we_s[1];
  assign bus0.addr = addr_s[0]; assign bus1.addr = addr_s[1];
  assign bus0.wdata = wdata_s[0]; assign bus1.wdata = wdata_s[1];
  assign bus0.ld_valid = ldv_s[0]; assign bus1.ld_valid = ldv_s[1];
  assign bus0.ld_data = ldd_s[0];  assign bus1.ld_data = ldd_s[1];
  assign rdata_s[0] = bus0.rdata; assign rdata_s[1] = bus1.rdata;
  assign ack_s[0] = bus0.ack;     assign ack_s[1] = bus1.ack;
  assign err_s[0] = bus0.err;     assign err_s[1] = bus1.err;
  assign busy_s[0] = bus0.busy;   assign busy_s[1] = bus1.busy;
  assign ldr_s[0] = bus0.ld_ready; assign ldr_s[1] = bus1.ld_ready;
  assign ldf_s[0] = bus0.ld_full;  assign ldf_s[1] = bus1.ld_full;

  // Reference model: plain word arrays, a load pointer and a full flag per instance
  int            wc [2] = '{0, 1};
  logic [DW-1:0] mem_m   [2][DEPTH];
  bit            known_m [2][DEPTH];
  int            ptr_m   [2];
  bit            full_m  [2];

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] last_rd;
  logic          last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_load(input int d, input logic [DW-1:0] v);
    if (!full_m[d]) begin
      mem_m[d][ptr_m[d]]   = v;
      known_m[d][ptr_m[d]] = 1'b1;
      if (ptr_m[d] == DEPTH - 1) full_m[d] = 1'b1;
      else                       ptr_m[d]++;
    end
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst_s[d] = 1'b0;
    req_s[d] = 1'b0;
    ldv_s[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", ack_s[d], 0);
    chk("rst_err", err_s[d], 0);
    chk("rst_rdata", rdata_s[d], 0);
    chk("rst_busy", busy_s[d], 0);
    chk("rst_ld_full", ldf_s[d], 0);
    chk("rst_ld_ready", ldr_s[d], 1);
    @(negedge clk);
    rst_s[d] = 1'b1;
    ptr_m[d]  = 0;
    full_m[d] = 1'b0;
  endtask

  task automatic load(input int d, input logic [DW-1:0] v);
    @(negedge clk);
    chk("ld_ready", ldr_s[d], !full_m[d]);
    ldv_s[d] = 1'b1;
    ldd_s[d] = v;
    @(posedge clk);
    #1;
    ldv_s[d] = 1'b0;
    model_load(d, v);
    chk("ld_full", ldf_s[d], full_m[d]);
  endtask

  task automatic access(input int d, input bit w, input logic [BW-1:0] a,
                        input logic [DW-1:0] wd, input bit chk_busy);
    int lat;
    bit got;
    bit busy_ok;
    bit inr;
    @(negedge clk);
    while (ack_s[d]) @(negedge clk);
    req_s[d] = 1'b1; we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
    got = 1'b0; lat = 0; busy_ok = 1'b1;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ack_s[d]) begin got = 1'b1; lat = k; end
      else if (!busy_s[d]) busy_ok = 1'b0;
    end
    req_s[d] = 1'b0;
    last_rd  = rdata_s[d];
    last_err = err_s[d];
    chk("ack_seen", got, 1);
    if (got) begin
      inr = (a[BW-1:AW] == '0);
      chk("latency", lat, wc[d] + 2);
      chk("err", err_s[d], !inr);
      if (chk_busy) chk("busy", {busy_ok, busy_s[d]}, 2'b10);
      if (!inr) chk("rdata_oor", rdata_s[d], 0);
      else if (!w && known_m[d][a[AW-1:0]]) chk("rdata", rdata_s[d], mem_m[d][a[AW-1:0]]);
      if (inr && w) begin
        mem_m[d][a[AW-1:0]]   = wd;
        known_m[d][a[AW-1:0]] = 1'b1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic [BW-1:0] a;
    int            lat;
    bit            got;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0; req_s[d] = 1'b0; we_s[d] = 1'b0; addr_s[d] = '0;
      wdata_s[d] = '0; ldv_s[d] = 1'b0; ldd_s[d] = '0;
      for (int i = 0; i < DEPTH; i++) known_m[d][i] = 1'b0;
    end
    do_reset(0);
    do_reset(1);

    // Boot load then read back, WAIT_CYC=1
    load(1, 16'hC000); load(1, 16'h0000); load(1, 16'hC040); load(1, 16'h0001);
    chk("t1_ld_full", ldf_s[1], 0);
    access(1, 1'b0, 16'h0002, 16'h0, 1'b1);
    chk("t1_rdata", last_rd, 16'hC040);

    access(1, 1'b1, 16'h0010, 16'hBEEF, 1'b1);
    access(1, 1'b0, 16'h0010, 16'h0, 1'b1);
    chk("t2_rdata", last_rd, 16'hBEEF);

    access(1, 1'b0, 16'h0100, 16'h0, 1'b0);
    chk("t3_err", last_err, 1);
    access(1, 1'b1, 16'h0100, 16'h7777, 1'b0);
    access(1, 1'b0, 16'h0000, 16'h0, 1'b0);
    chk("t3_addr0", last_rd, 16'hC000);

    // Reset in the middle of a write's wait state
    access(1, 1'b1, 16'h0005, 16'hA5A5, 1'b0);
    @(negedge clk);
    while (ack_s[1]) @(negedge clk);
    req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 16'h0005; wdata_s[1] = 16'h1234;
    @(posedge clk);
    #1;
    chk("t4_busy_wait", busy_s[1], 1);
    rst_s[1] = 1'b0;
    #1;
    chk("t4_busy_rst", busy_s[1], 0);
    req_s[1] = 1'b0;
    got = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack_s[1]) got = 1'b1; end
    chk("t4_no_ack", got, 0);
    @(negedge clk);
    rst_s[1] = 1'b1;
    ptr_m[1] = 0; full_m[1] = 1'b0;
    access(1, 1'b0, 16'h0005, 16'h0, 1'b0);
    chk("t4_rdata", last_rd, 16'hA5A5);

    // Load and request together: load wins, request follows one edge later
    v = 16'($urandom);
    @(negedge clk);
    while (ack_s[1]) @(negedge clk);
    ldv_s[1] = 1'b1; ldd_s[1] = v;
    req_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = BW'(ptr_m[1]);
    chk("t5_ld_ready", ldr_s[1], 1);
    a = BW'(ptr_m[1]);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin ldv_s[1] = 1'b0; model_load(1, v); end
      if (ack_s[1]) begin got = 1'b1; lat = k; end
    end
    req_s[1] = 1'b0;
    chk("t5_latency", lat, wc[1] + 3);
    chk("t5_rdata", rdata_s[1], mem_m[1][a[AW-1:0]]);

    // Fill the WAIT_CYC=0 instance completely, then overrun by one
    for (int i = 0; i < DEPTH; i++) load(0, 16'($urandom));
    v = ~mem_m[0][DEPTH-1];
    @(negedge clk);
    chk("t6_ld_ready_full", ldr_s[0], 0);
    ldv_s[0] = 1'b1; ldd_s[0] = v;
    @(posedge clk);
    #1;
    ldv_s[0] = 1'b0;
    chk("t6_ld_full", ldf_s[0], 1);
    access(0, 1'b0, 16'h00FF, 16'h0, 1'b1);
    access(0, 1'b0, 16'h0000, 16'h0, 1'b1);

    // Random traffic against the model on both instances
    for (int n = 0; n < 400; n++) begin
      int d;
      int sel;
      d   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 99));
      if (sel < 15) begin
        load(d, 16'($urandom));
      end else if (sel < 50) begin
        access(d, 1'b1, BW'($urandom_range(0, DEPTH - 1)), 16'($urandom), 1'b1);
      end else if (sel < 90) begin
        a = BW'($urandom_range(0, DEPTH - 1));
        for (int t = 0; t < 8 && !known_m[d][a[AW-1:0]]; t++) a = BW'($urandom_range(0, DEPTH - 1));
        access(d, 1'b0, a, 16'h0, 1'b1);
      end else begin
        a = BW'($urandom_range(DEPTH, 65535));
        access(d, sel[0], a, 16'($urandom), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
Parametrised single-port main memory with a request/acknowledge handshake, a programmable wait-state counter, and address-range checking.
It also has a sequential boot-load port, so program images are streamed in after reset instead of being hard-coded.
It sits between the CPU datapath (fetch/load/store) and the memory array, and replaces the fixed 256x16 combinational-read memory.

Parameters:
DATA_W, 16, data word width in bits
ADDR_W, 8, internal word-address width; DEPTH = 2**ADDR_W words
BUS_ADDR_W, 16, CPU-side address width (must be >= ADDR_W)
WAIT_CYC, 1, extra wait-state cycles inserted before each access (0 allowed)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
req  in  1  access request from CPU, held until ack is seen
we  in  1  1 = write, 0 = read; sampled with req
addr  in  BUS_ADDR_W  word address; sampled with req
wdata  in  DATA_W  write data; sampled with req
rdata  out  DATA_W  read data, valid while ack=1; held afterwards
ack  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with ack when the address is out of range
busy  out  1  high whenever state != IDLE
ld_valid  in  1  boot-load word valid
ld_data  in  DATA_W  boot-load word
ld_ready  out  1  load word accepted this cycle (combinational: state==IDLE && !ld_full)
ld_full  out  1  all DEPTH words loaded; further ld_valid is ignored

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; rdata=0; ack=0; err=0; ld_ptr=0; ld_full=0; wait counter=0.
  - Array contents are not reset.
- States:
  - IDLE -> WAIT on accept when WAIT_CYC>0; IDLE -> ACC on accept when WAIT_CYC=0.
  - WAIT -> ACC when the counter reaches WAIT_CYC-1.
  - ACC -> IDLE always.
- Accept condition:
  - In IDLE with req=1 && ack=0 && ld_valid=0: latch we, addr, wdata.
  - ld_valid has priority over req in IDLE; req stays pending.
- ACC edge:
  - In range (addr[BUS_ADDR_W-1:ADDR_W]==0): a write stores the latched wdata; a read registers array[addr] into rdata.
  - Out of range: no array access, rdata<=0, err<=1.
  - In both cases ack<=1 for exactly one cycle.
- Latency: ack is high in the cycle WAIT_CYC+2 edges after the accepting edge (WAIT_CYC=0 gives 2 edges).
- The master must drop req in the ack cycle. The ack=0 gating prevents a re-accept on the same cycle.
- A write is committed only at the ACC edge. Reset asserted during WAIT aborts with no array change and no ack.
- Boot load:
  - In IDLE, ld_valid && !ld_full writes ld_data to array[ld_ptr] and increments ld_ptr.
  - When ld_ptr reaches DEPTH-1 and that word is written, ld_full<=1 and ld_ptr stays at DEPTH-1 (no wrap).
- Reads return the value written by an earlier completed write; there is no bypass requirement beyond that.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, WAIT=2'd1, ACC=2'd2);
  - default DATA_W/ADDR_W;
  - the opcode/field constants already used by the CPU's instruction words.
- One sub-module, mem_array: synchronous-write, synchronous-read DATA_W x DEPTH RAM with one port. The controller muxes the load port and CPU port onto it.

Test Plan:
1. Reset, then 4 load words 0xC000,0x0000,0xC040,0x0001 -> ld_ptr=4, ld_full=0. Read addr 2 -> rdata=0xC040, ack at accept+3 edges (WAIT_CYC=1).
2. Write addr 0x0010 data 0xBEEF, then read 0x0010 -> read ack with rdata=0xBEEF, err=0; busy high from accept through the ACC cycle.
3. Read addr 0x0100 (out of range, ADDR_W=8) -> ack=1, err=1, rdata=0x0000; no array word changes (re-read addr 0x00 is unchanged).
4. Assert rst=0 during WAIT of a write to addr 5 (value 0x1234) -> no ack; after reset, read addr 5 returns the prior value.
5. ld_valid and req asserted together in IDLE -> load accepted first (ld_ready=1); req is accepted the next IDLE cycle and completes normally.
6. Stream DEPTH=256 load words -> ld_full=1 after the 256th; a 257th ld_valid gives ld_ready=0 and array[255] is unchanged. With WAIT_CYC=0, read latency is 2 edges.
